// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory load/store port among N_CORES channels.
// Only one transaction is in flight at a time. The winner's command is latched
// at grant. Completion is reported as a one-cycle ack pulse, or as an err pulse
// if memory fails to answer within TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int N_CORES   = 4,
  parameter int DATA_SIZE = 32,
  parameter int ADDR_W    = 11,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CORES-1:0]            core_req,
  input  logic [N_CORES-1:0]            core_we,
  input  logic [N_CORES*ADDR_W-1:0]     core_adrs,
  input  logic [N_CORES*DATA_SIZE-1:0]  core_wdata,
  output logic [N_CORES-1:0]            core_ack,
  output logic [N_CORES-1:0]            core_err,
  output logic [DATA_SIZE-1:0]          core_rdata,
  output logic [$clog2(N_CORES)-1:0]    grant_id,
  output logic                          busy,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_adrs,
  output logic [DATA_SIZE-1:0]          mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_SIZE-1:0]          mem_rdata
);

  localparam int GW = $clog2(N_CORES);
  // The counter only has to reach TIMEOUT-1 before the error fires.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TMO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          last_q, last_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_adrs_q, mem_adrs_d;
  logic [DATA_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic [N_CORES-1:0]     ack_q, ack_d;
  logic [N_CORES-1:0]     err_q, err_d;
  logic [DATA_SIZE-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [GW-1:0]          winner;
  logic                   anyReq;
  int                     probe;
  logic [GW-1:0]          probeIdx;
  logic                   winWe;
  logic [ADDR_W-1:0]      winAdrs;
  logic [DATA_SIZE-1:0]   winWdata;
  logic [N_CORES-1:0]     grantOneHot;

  // Round-robin search starting just after the last winner. Probing runs from the
  // farthest offset down to the nearest, so the nearest requester is assigned last and wins.
  always_comb begin
    winner   = '0;
    anyReq   = 1'b0;
    probe    = 0;
    probeIdx = '0;
    for (int i = N_CORES; i >= 1; i--) begin
      probe    = (int'(last_q) + i) % N_CORES;
      probeIdx = probe[GW-1:0];
      if (core_req[probeIdx]) begin
        winner = probeIdx;
        anyReq = 1'b1;
      end
    end
  end

  // Select the winning channel's command fields out of the flattened buses.
  always_comb begin
    winWe    = 1'b0;
    winAdrs  = '0;
    winWdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (winner == GW'(i)) begin
        winWe    = core_we[i];
        winAdrs  = core_adrs[i*ADDR_W +: ADDR_W];
        winWdata = core_wdata[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign grantOneHot = {{(N_CORES-1){1'b0}}, 1'b1} << grant_q;

  // Next-state logic for the grant / wait-for-memory / release cycle.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_adrs_d  = mem_adrs_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          grant_d     = winner;
          last_d      = winner;
          mem_req_d   = 1'b1;
          mem_we_d    = winWe;
          mem_adrs_d  = winAdrs;
          mem_wdata_d = winWdata;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ack_d     = grantOneHot;
          rdata_d   = mem_we_q ? '0 : mem_rdata;
          state_d   = RELEASE;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          mem_req_d = 1'b0;
          err_d     = grantOneHot;
          rdata_d   = '0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GW'(N_CORES - 1);
      grant_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adrs_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adrs_q  <= mem_adrs_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign core_ack   = ack_q;
  assign core_err   = err_q;
  assign core_rdata = rdata_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_adrs   = mem_adrs_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: four channels, timeout of 8 cycles.
module tb_mem_port_arbiter;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int AW = 11;

  logic              clk;
  logic              rst;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_we;
  logic [NC*AW-1:0]  core_adrs;
  logic [NC*DW-1:0]  core_wdata;
  logic [NC-1:0]     core_ack;
  logic [NC-1:0]     core_err;
  logic [DW-1:0]     core_rdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_adrs;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;

  typedef struct {
    logic [1:0]    gid;
    logic          we;
    logic [AW-1:0] adrs;
    logic [DW-1:0] wdata;
    int            cycles;
    int            gap;
  } memExp_t;

  typedef struct {
    logic [NC-1:0] ack;
    logic [NC-1:0] err;
    logic [DW-1:0] rdata;
  } respExp_t;

  memExp_t  expMemQ[$];
  respExp_t expRespQ[$];

  int checks = 0;
  int errors = 0;

  int      memLatency = 1;
  logic    memNoAck   = 1'b0;
  logic    strayReq   = 1'b0;
  logic [DW-1:0] memData = '0;

  mem_port_arbiter #(
    .N_CORES(NC),
    .DATA_SIZE(DW),
    .ADDR_W(AW),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_req(core_req),
    .core_we(core_we),
    .core_adrs(core_adrs),
    .core_wdata(core_wdata),
    .core_ack(core_ack),
    .core_err(core_err),
    .core_rdata(core_rdata),
    .grant_id(grant_id),
    .busy(busy),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_adrs(mem_adrs),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic pushExpect(input logic [1:0] gid, input logic we, input logic [AW-1:0] adrs,
                            input logic [DW-1:0] wdata, input int cycles, input int gap,
                            input logic withResp, input logic [NC-1:0] ack,
                            input logic [NC-1:0] err, input logic [DW-1:0] rdata);
    memExp_t  m;
    respExp_t r;
    m.gid = gid; m.we = we; m.adrs = adrs; m.wdata = wdata; m.cycles = cycles; m.gap = gap;
    expMemQ.push_back(m);
    if (withResp) begin
      r.ack = ack; r.err = err; r.rdata = rdata;
      expRespQ.push_back(r);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic we, input logic [AW-1:0] adrs, input logic [DW-1:0] wdata);
    core_we[ch]             = we;
    core_adrs[ch*AW +: AW]  = adrs;
    core_wdata[ch*DW +: DW] = wdata;
    core_req[ch]            = 1'b1;
  endtask

  // Holds each request until its channel sees ack or err, then drops it.
  task automatic drainRequests(input int maxCycles);
    int n = 0;
    while (core_req != '0 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
      for (int ch = 0; ch < NC; ch++)
        if (core_ack[ch] || core_err[ch]) core_req[ch] = 1'b0;
    end
    if (core_req != '0) begin
      checks++; errors++;
      $display("[TB] FAIL drainTimeout actual=%0h required=0", core_req);
      core_req = '0;
    end
  endtask

  task automatic waitMemReq(input int maxCycles);
    int n = 0;
    while (!mem_req && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("memReqSeen", {31'b0, mem_req}, 32'h1);
  endtask

  // Memory model: acks during the memLatency-th cycle of mem_req, or never when memNoAck.
  initial begin
    int reqCycles;
    reqCycles = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ack   = 1'b0;
      mem_rdata = memData;
      if (mem_req && !memNoAck) begin
        reqCycles++;
        if (reqCycles == memLatency) mem_ack = 1'b1;
      end else if (!mem_req) begin
        reqCycles = 0;
        mem_ack   = strayReq;
      end
    end
  end

  // Monitor: pops expectations when mem_req rises and when an ack/err pulse appears.
  initial begin
    memExp_t  curMem;
    respExp_t r;
    logic          prevReq;
    logic [NC-1:0] prevPulse;
    logic [NC-1:0] pulse;
    int cyc, lastRise, highCnt;
    prevReq = 1'b0; prevPulse = '0; cyc = 0; lastRise = 0; highCnt = 0;
    curMem.gid = '0; curMem.we = 1'b0; curMem.adrs = '0; curMem.wdata = '0;
    curMem.cycles = 0; curMem.gap = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prevReq   = 1'b0;
        prevPulse = '0;
      end else begin
        if (mem_req && !prevReq) begin
          if (expMemQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpectedMemReq actual=%0h required=none", mem_adrs);
          end else begin
            curMem = expMemQ.pop_front();
            checkOutput("grantId", {30'b0, grant_id}, {30'b0, curMem.gid});
            checkOutput("memWe", {31'b0, mem_we}, {31'b0, curMem.we});
            checkOutput("memAdrs", {21'b0, mem_adrs}, {21'b0, curMem.adrs});
            checkOutput("memWdata", mem_wdata, curMem.wdata);
            if (curMem.gap != 0) checkOutput("reqGap", cyc - lastRise, curMem.gap);
          end
          lastRise = cyc;
          highCnt  = 1;
        end else if (mem_req && prevReq) begin
          highCnt++;
          checkOutput("memAdrsStable", {21'b0, mem_adrs}, {21'b0, curMem.adrs});
          checkOutput("memWeStable", {31'b0, mem_we}, {31'b0, curMem.we});
          checkOutput("memWdataStable", mem_wdata, curMem.wdata);
        end else if (!mem_req && prevReq && curMem.cycles != 0) begin
          checkOutput("memReqCycles", highCnt, curMem.cycles);
        end
        pulse = core_ack | core_err;
        if (pulse != '0) begin
          checkOutput("pulseWidth", {28'b0, prevPulse}, 32'h0);
          if (expRespQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpectedResp actual=%0h required=none", pulse);
          end else begin
            r = expRespQ.pop_front();
            checkOutput("coreAck", {28'b0, core_ack}, {28'b0, r.ack});
            checkOutput("coreErr", {28'b0, core_err}, {28'b0, r.err});
            checkOutput("coreRdata", core_rdata, r.rdata);
          end
        end
        prevReq   = mem_req;
        prevPulse = pulse;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int pulses;
    rst = 1'b1; core_req = '0; core_we = '0; core_adrs = '0; core_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstMemReq", {31'b0, mem_req}, 32'h0);
    checkOutput("rstBusy", {31'b0, busy}, 32'h0);
    checkOutput("rstGrant", {30'b0, grant_id}, 32'h0);
    checkOutput("rstAck", {28'b0, core_ack | core_err}, 32'h0);
    checkOutput("rstRdata", core_rdata, 32'h0);
    rst = 1'b0;

    // Single load on channel 0.
    memLatency = 2; memData = 32'hDEADBEEF;
    pushExpect(2'd0, 1'b0, 11'h010, 32'h0, 2, 0, 1'b1, 4'b0001, 4'b0000, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 11'h010, 32'h0);
    @(posedge clk); #1;
    checkOutput("memReqLatency", {31'b0, mem_req}, 32'h1);
    drainRequests(50);
    checkOutput("busyRelease", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    checkOutput("busyIdle", {31'b0, busy}, 32'h0);
    checkOutput("rdataHeld", core_rdata, 32'hDEADBEEF);

    // Round-robin fairness after a fresh reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    memLatency = 1; memData = 32'h600DF00D;
    pushExpect(2'd0, 1'b0, 11'h100, 32'h0, 1, 0, 1'b1, 4'b0001, 4'b0000, 32'h600DF00D);
    pushExpect(2'd1, 1'b0, 11'h101, 32'h0, 1, 3, 1'b1, 4'b0010, 4'b0000, 32'h600DF00D);
    pushExpect(2'd2, 1'b0, 11'h102, 32'h0, 1, 3, 1'b1, 4'b0100, 4'b0000, 32'h600DF00D);
    pushExpect(2'd3, 1'b0, 11'h103, 32'h0, 1, 3, 1'b1, 4'b1000, 4'b0000, 32'h600DF00D);
    pushExpect(2'd0, 1'b0, 11'h100, 32'h0, 1, 3, 1'b1, 4'b0001, 4'b0000, 32'h600DF00D);
    pushExpect(2'd1, 1'b0, 11'h101, 32'h0, 1, 3, 1'b1, 4'b0010, 4'b0000, 32'h600DF00D);
    for (int ch = 0; ch < NC; ch++) applyStimulus(ch, 1'b0, 11'h100 + 11'(ch), 32'h0);
    pulses = 0;
    for (int n = 0; n < 100 && pulses < 6; n++) begin
      @(posedge clk); #1;
      if ((core_ack | core_err) != '0) pulses++;
    end
    core_req = '0;
    checkOutput("rrPulseCount", pulses, 6);

    // Store on channel 2.
    memLatency = 3; memData = 32'h0BADC0DE;
    pushExpect(2'd2, 1'b1, 11'h7FF, 32'h12345678, 3, 0, 1'b1, 4'b0100, 4'b0000, 32'h0);
    applyStimulus(2, 1'b1, 11'h7FF, 32'h12345678);
    drainRequests(50);

    // Ack on the final allowed cycle beats the timeout.
    memLatency = 8; memData = 32'h13579BDF;
    pushExpect(2'd1, 1'b0, 11'h0AB, 32'h0, 8, 0, 1'b1, 4'b0010, 4'b0000, 32'h13579BDF);
    applyStimulus(1, 1'b0, 11'h0AB, 32'h0);
    drainRequests(50);

    // No ack at all: error after exactly 8 cycles of mem_req.
    memNoAck = 1'b1;
    pushExpect(2'd1, 1'b0, 11'h0AA, 32'h0, 8, 0, 1'b1, 4'b0000, 4'b0010, 32'h0);
    applyStimulus(1, 1'b0, 11'h0AA, 32'h0);
    drainRequests(50);
    memNoAck = 1'b0;

    // Address change after grant must not reach the memory port.
    memLatency = 4; memData = 32'h0F0F0F0F;
    pushExpect(2'd0, 1'b0, 11'h020, 32'h0, 4, 0, 1'b1, 4'b0001, 4'b0000, 32'h0F0F0F0F);
    applyStimulus(0, 1'b0, 11'h020, 32'h0);
    waitMemReq(20);
    @(posedge clk); #1;
    core_adrs[0 +: AW] = 11'h030;
    drainRequests(50);

    // Stray mem_ack while idle.
    repeat (2) @(posedge clk);
    #1;
    strayReq = 1'b1;
    @(posedge clk); #1;
    strayReq = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checkOutput("strayAck", {28'b0, core_ack}, 32'h0);
      checkOutput("strayBusy", {31'b0, busy}, 32'h0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a store.
    memLatency = 20;
    pushExpect(2'd0, 1'b1, 11'h055, 32'hA5A5A5A5, 0, 0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    applyStimulus(0, 1'b1, 11'h055, 32'hA5A5A5A5);
    waitMemReq(20);
    @(posedge clk); #1;
    rst = 1'b1;
    core_req = '0;
    @(posedge clk); #1;
    checkOutput("midRstMemReq", {31'b0, mem_req}, 32'h0);
    checkOutput("midRstMemWe", {31'b0, mem_we}, 32'h0);
    checkOutput("midRstMemAdrs", {21'b0, mem_adrs}, 32'h0);
    checkOutput("midRstMemWdata", mem_wdata, 32'h0);
    checkOutput("midRstRdata", core_rdata, 32'h0);
    checkOutput("midRstBusy", {31'b0, busy}, 32'h0);
    checkOutput("midRstPulse", {28'b0, core_ack | core_err}, 32'h0);
    rst = 1'b0;

    // Channels 1 and 3 together after reset: channel 1 wins first.
    memLatency = 1; memData = 32'h24680ACE;
    pushExpect(2'd1, 1'b0, 11'h111, 32'h0, 1, 0, 1'b1, 4'b0010, 4'b0000, 32'h24680ACE);
    pushExpect(2'd3, 1'b0, 11'h333, 32'h0, 1, 0, 1'b1, 4'b1000, 4'b0000, 32'h24680ACE);
    applyStimulus(1, 1'b0, 11'h111, 32'h0);
    applyStimulus(3, 1'b0, 11'h333, 32'h0);
    drainRequests(50);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("memQueueDrained", expMemQ.size(), 32'h0);
    checkOutput("respQueueDrained", expRespQ.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory load/store port among N_CORES requesters, generalising the single-core load/store path to N channels.
- Round-robin arbitration with one outstanding transaction at a time.
- Provides a timeout/error response, per-transaction data return and a grant indication.
- Sits between the cores' load/store interfaces and a memory data port, all in one clock domain.

Parameters:
N_CORES, 4, number of requesting channels (2..16)
DATA_SIZE, 32, data width
ADDR_W, 11, word address width
TIMEOUT, 64, max cycles waiting for mem_ack before error; 0 disables timeout

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
core_req  input  N_CORES  per-channel request level, held until core_ack/core_err
core_we  input  N_CORES  per-channel 1=store, 0=load
core_adrs  input  N_CORES*ADDR_W  flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
core_wdata  input  N_CORES*DATA_SIZE  flattened store data, channel i at [i*DATA_SIZE +: DATA_SIZE]
core_ack  output  N_CORES  one-cycle completion pulse, one-hot
core_err  output  N_CORES  one-cycle timeout pulse, one-hot
core_rdata  output  DATA_SIZE  load data; valid in the core_ack cycle
grant_id  output  $clog2(N_CORES)  channel currently/last granted
busy  output  1  high in BUSY and RELEASE
mem_req  output  1  memory request, held until mem_ack or timeout
mem_we  output  1  store when 1
mem_adrs  output  ADDR_W  memory address
mem_wdata  output  DATA_SIZE  store data
mem_ack  input  1  memory completion, single-cycle
mem_rdata  input  DATA_SIZE  load data, valid with mem_ack

Behaviour:
- Reset (rst high at an edge, including mid-transaction):
  - State IDLE.
  - All outputs 0, grant_id 0.
  - Round-robin pointer last = N_CORES-1, so channel 0 has top priority after reset.
  - Timeout counter 0. Any in-flight transaction is abandoned without ack/err.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any core_req is high at an edge, the winner is the first requesting channel searching last+1, last+2, ... with modulo-N_CORES wrap.
  - Latch the winner's we/adrs/wdata into mem_we/mem_adrs/mem_wdata.
  - grant_id <= winner, last <= winner, mem_req <= 1, counter <= 0, go to BUSY.
  - With no requests, stay in IDLE; mem_req stays 0.
- BUSY:
  - mem_req, mem_we, mem_adrs and mem_wdata are held stable.
  - Counter increments each cycle.
  - On mem_ack:
    - mem_req <= 0; core_ack[grant_id] <= 1.
    - core_rdata <= mem_rdata for a load, 0 for a store.
    - Go to RELEASE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: mem_req <= 0, core_err[grant_id] <= 1, core_rdata <= 0, go to RELEASE.
  - If mem_ack and timeout coincide, mem_ack wins and no err is raised.
- RELEASE:
  - core_ack/core_err are high for exactly this one cycle; they clear at the next edge.
  - core_req is not sampled, so the requester can drop its request.
  - Next state IDLE.
- core_rdata holds its value until the next ack or err.
- Latency: core_req sampled at edge k gives mem_req high from k+1. mem_ack sampled at edge m gives core_ack high from m+1 to m+2. The next grant is taken at edge m+2. Minimum turnaround is 3 cycles per transaction.
- mem_ack outside BUSY is ignored.
- Changes to core_adrs/core_wdata/core_we after the grant are ignored; values are latched at grant.
- Requests from non-granted channels wait with no loss and no starvation: every requesting channel is served within N_CORES grants.
- grant_id is undefined-free: it always holds a valid index in the range 0..N_CORES-1.

Test Plan:
- Reset then single load: core_req=0001, core_we=0, adrs0=0x010; memory acks 2 cycles after mem_req with rdata 0xDEADBEEF -> mem_req high at k+1, mem_adrs=0x010, core_ack=0001 for one cycle, core_rdata=0xDEADBEEF, busy low two cycles after ack.
- Round-robin fairness: all four channels request continuously, memory acks immediately -> grant order 0,1,2,3,0,1; each core_ack one-hot; 3 cycles between consecutive mem_req rises.
- Store: channel 2 with we=1, adrs=0x7FF, wdata=0x12345678 -> mem_we=1, mem_adrs=0x7FF, mem_wdata=0x12345678 stable while mem_req high; core_ack=0100; core_rdata=0.
- Timeout: TIMEOUT=8, channel 1 requests, mem_ack never asserted -> mem_req high exactly 8 cycles, core_err=0010 one cycle, core_ack stays 0; with mem_ack on the 8th cycle -> core_ack instead, no err.
- Reset mid-transaction: rst asserted in BUSY -> next cycle all outputs 0; after release, with channels 1 and 3 requesting, channel 1 is granted first.
- Input change after grant: channel 0 changes adrs from 0x020 to 0x030 one cycle after grant -> mem_adrs remains 0x020 until ack; a stray mem_ack in IDLE produces no core_ack.
